// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, stack depth and command decode for the program counter unit
package cpu_pkg;

  localparam int CPU_W_DEFAULT     = 8;
  localparam int CPU_DEPTH_DEFAULT = 4;

  typedef enum logic [2:0] {
    CMD_HOLD,
    CMD_INC,
    CMD_LOAD,
    CMD_CALL,
    CMD_RET
  } cmd_t;

  // One command per cycle: ret beats call beats load beats increment.
  function automatic cmd_t decode_cmd(input logic ret, input logic call,
                                      input logic lp, input logic c);
    if (ret)       return CMD_RET;
    else if (call) return CMD_CALL;
    else if (lp)   return CMD_LOAD;
    else if (c)    return CMD_INC;
    else           return CMD_HOLD;
  endfunction

endpackage

// File: rtl/cpu_pcu_lifo.sv
// rtl/cpu_pcu_lifo.sv - return-address stack with registered occupancy count
module cpu_pcu_lifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] top_idx;

  // At count == DEPTH the low bits are zero, so the subtraction wraps to DEPTH-1.
  assign top_idx = count[AW-1:0] - AW'(1);
  assign dout    = mem[top_idx];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[count[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/cpu_pcu.sv
// rtl/cpu_pcu.sv - program counter with jump, increment and optional call/return stack
// Define CPU_PCU_STACK_EN to include the return-address stack; otherwise call/ret are ignored.
module cpu_pcu
  import cpu_pkg::*;
#(
  parameter int W     = CPU_W_DEFAULT,
  parameter int DEPTH = CPU_DEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] bus_in,
  input  logic         lp,
  input  logic         c,
  input  logic         call,
  input  logic         ret,
  output logic [W-1:0] bus_out,
  output logic         wrap,
  output logic         stk_full,
  output logic         stk_empty,
  output logic         stk_err
);

  logic [W-1:0] pc;
  logic [W-1:0] pc_nxt;
  logic         wrap_nxt;
  logic [W:0]   inc_full;
  cmd_t         cmd;

  assign inc_full = {1'b0, pc} + (W+1)'(1);
  assign bus_out  = pc;

`ifdef CPU_PCU_STACK_EN
  logic                   full;
  logic                   empty;
  logic                   err_set;
  logic [W-1:0]           top;
  logic [$clog2(DEPTH):0] occ_unused;

  assign cmd = decode_cmd(ret, call, lp, c);

  // The pushed return address is the incremented counter, so a call at all-ones stores 0.
  cpu_pcu_lifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_lifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd == CMD_CALL),
    .pop   (cmd == CMD_RET),
    .din   (inc_full[W-1:0]),
    .dout  (top),
    .full  (full),
    .empty (empty),
    .count (occ_unused)
  );

  assign stk_full  = full;
  assign stk_empty = empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stk_err <= 1'b0;
    end else if (err_set) begin
      stk_err <= 1'b1;
    end
  end
`else
  logic stack_unused;

  assign stack_unused = call | ret;
  assign cmd          = decode_cmd(1'b0, 1'b0, lp, c);
  assign stk_full     = 1'b0;
  assign stk_empty    = 1'b1;
  assign stk_err      = 1'b0;
`endif

  always_comb begin
    pc_nxt   = pc;
    wrap_nxt = 1'b0;
`ifdef CPU_PCU_STACK_EN
    err_set  = 1'b0;
`endif
    case (cmd)
      CMD_LOAD: pc_nxt = bus_in;
      CMD_INC:  {wrap_nxt, pc_nxt} = inc_full;
`ifdef CPU_PCU_STACK_EN
      CMD_CALL: begin
        if (full) err_set = 1'b1;
        else      pc_nxt  = bus_in;
      end
      CMD_RET: begin
        if (empty) err_set = 1'b1;
        else       pc_nxt  = top;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc   <= '0;
      wrap <= 1'b0;
    end else begin
      pc   <= pc_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule
